// File: rtl/eclock_pkg.sv
// Shared types for the eclock configuration sequencer: state encoding,
// divider codes and a constant helper for sizing the shared timer.
package eclock_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,  // outputs stable, clock off
        ST_PLL_RST   = 3'd1,  // PLL held in reset
        ST_LOCK_WAIT = 3'd2,  // waiting for PLL lock
        ST_QUIESCE   = 3'd3,  // clock gated before divider change
        ST_APPLY     = 3'd4,  // divider updated
        ST_SETTLE    = 3'd5,  // clock gated after divider change
        ST_RUN       = 3'd6,  // clock enabled
        ST_ERROR     = 3'd7   // lock timeout
    } state_t;

    localparam logic [3:0] DIV_OFF = 4'h0;
    localparam logic [3:0] DIV_1   = 4'h7;
    localparam logic [3:0] DIV_2   = 4'h6;
    localparam logic [3:0] DIV_4   = 4'h5;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/eclock_ctrl_timer.sv
// Loadable down-counter shared by every timed state; stops at zero.
module eclock_ctrl_timer #(
    parameter int W = 11
) (
    input  logic         clk,
    input  logic         nreset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!nreset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - W'(1);
        end
    end

    assign done = (cnt == '0);

endmodule

// File: rtl/eclock_ctrl.sv
// Glitch-safe sequencer for the eclock enable, divider and PLL configuration.
// Optional lock watchdog in RUN: define ECLOCK_CTRL_WATCHDOG_EN.
module eclock_ctrl
    import eclock_pkg::*;
#(
    parameter int OFF_CYCLES    = 16,
    parameter int PLLRST_CYCLES = 8,
    parameter int LOCK_TIMEOUT  = 1024
) (
    input  logic       clk,
    input  logic       nreset,
    input  logic       cfg_valid,
    output logic       cfg_ready,
    input  logic       cfg_en,
    input  logic [3:0] cfg_div,
    input  logic [3:0] cfg_pllcfg,
    input  logic       pll_locked,
    output logic       pll_reset,
    output logic       cclk_en,
    output logic [3:0] cclk_div,
    output logic [3:0] cclk_pllcfg,
    output logic       busy,
    output logic       err_timeout,
    output logic       lock_lost
);

    localparam int CNT_W = $clog2(max3(OFF_CYCLES, PLLRST_CYCLES, LOCK_TIMEOUT)) + 1;
    localparam logic [CNT_W-1:0] LD_OFF  = CNT_W'(OFF_CYCLES - 1);
    localparam logic [CNT_W-1:0] LD_PRST = CNT_W'(PLLRST_CYCLES - 1);
    localparam logic [CNT_W-1:0] LD_LOCK = CNT_W'(LOCK_TIMEOUT - 1);

    state_t           state_q, state_d, route;
    logic             fresh_q;
    logic             cap_en_q, cap_en_d;
    logic [3:0]       cap_div_q, cap_div_d, cap_pll_q, cap_pll_d;
    logic             accept, ready_d, wd_trip;
    logic             timer_load, timer_done;
    logic [CNT_W-1:0] timer_val;

    assign accept    = cfg_valid & cfg_ready;
    assign cap_en_d  = accept ? cfg_en     : cap_en_q;
    assign cap_div_d = accept ? cfg_div    : cap_div_q;
    assign cap_pll_d = accept ? cfg_pllcfg : cap_pll_q;

    always_comb begin
        state_d = state_q;
        if ((cfg_pllcfg != cclk_pllcfg) || (state_q == ST_ERROR)) begin
            route = ST_PLL_RST;
        end else if (cclk_en) begin
            route = ST_QUIESCE;
        end else begin
            route = ST_APPLY;
        end
        case (state_q)
            ST_IDLE, ST_ERROR: if (accept) state_d = route;
            ST_RUN: begin
                if (accept)       state_d = route;
                else if (wd_trip) state_d = ST_PLL_RST;
            end
            // the cycle straight out of reset only loads the timer
            ST_PLL_RST:   if (timer_done && !fresh_q) state_d = ST_LOCK_WAIT;
            ST_LOCK_WAIT: begin
                if (pll_locked)      state_d = ST_APPLY;
                else if (timer_done) state_d = ST_ERROR;
            end
            ST_QUIESCE:   if (timer_done) state_d = ST_APPLY;
            ST_APPLY:     state_d = ST_SETTLE;
            ST_SETTLE: begin
                if (timer_done) begin
                    state_d = (cap_en_q && (cap_div_q != DIV_OFF)) ? ST_RUN : ST_IDLE;
                end
            end
            default:      state_d = ST_PLL_RST;
        endcase
    end

    always_comb begin
        timer_load = fresh_q || (state_d != state_q);
        timer_val  = '0;
        case (state_d)
            ST_PLL_RST:            timer_val = LD_PRST;
            ST_LOCK_WAIT:          timer_val = LD_LOCK;
            ST_QUIESCE, ST_SETTLE: timer_val = LD_OFF;
            default:               timer_val = '0;
        endcase
        ready_d = (state_d == ST_IDLE) || (state_d == ST_RUN) || (state_d == ST_ERROR);
    end

    eclock_ctrl_timer #(.W(CNT_W)) u_timer (
        .clk      (clk),
        .nreset   (nreset),
        .load     (timer_load),
        .load_val (timer_val),
        .done     (timer_done)
    );

    always_ff @(posedge clk) begin
        if (!nreset) begin
            state_q     <= ST_PLL_RST;
            fresh_q     <= 1'b1;
            cap_en_q    <= 1'b0;
            cap_div_q   <= DIV_OFF;
            cap_pll_q   <= 4'h0;
            pll_reset   <= 1'b1;
            cclk_en     <= 1'b0;
            cclk_div    <= DIV_OFF;
            cclk_pllcfg <= 4'h0;
            cfg_ready   <= 1'b0;
            busy        <= 1'b1;
            err_timeout <= 1'b0;
        end else begin
            state_q   <= state_d;
            fresh_q   <= 1'b0;
            cap_en_q  <= cap_en_d;
            cap_div_q <= cap_div_d;
            cap_pll_q <= cap_pll_d;
            pll_reset <= (state_d == ST_PLL_RST);
            cclk_en   <= (state_d == ST_RUN);
            if (state_d == ST_APPLY)   cclk_div    <= cap_div_d;
            if (state_d == ST_PLL_RST) cclk_pllcfg <= cap_pll_d;
            cfg_ready <= ready_d;
            busy      <= ~ready_d;
            if (accept)                    err_timeout <= 1'b0;
            else if (state_d == ST_ERROR)  err_timeout <= 1'b1;
        end
    end

`ifdef ECLOCK_CTRL_WATCHDOG_EN
    logic wd_low_q;

    // two consecutive low samples of lock while running trip the watchdog
    assign wd_trip = (state_q == ST_RUN) && !pll_locked && wd_low_q;

    always_ff @(posedge clk) begin
        if (!nreset) begin
            wd_low_q  <= 1'b0;
            lock_lost <= 1'b0;
        end else begin
            wd_low_q <= (state_q == ST_RUN) && !pll_locked;
            if (accept)       lock_lost <= 1'b0;
            else if (wd_trip) lock_lost <= 1'b1;
        end
    end
`else
    assign wd_trip   = 1'b0;
    assign lock_lost = 1'b0;
`endif

endmodule

// File: tb/tb_eclock_ctrl.sv
// Self-checking bench for eclock_ctrl: reset, request table, hold-off,
// lock timeout, watchdog and randomized requests against a phase-plan model.
module tb_eclock_ctrl;
    import eclock_pkg::*;

    localparam int OFF  = 16;
    localparam int PRST = 8;
    localparam int LTO  = 1024;

    logic       clk = 1'b0;
    logic       nreset = 1'b0;
    logic       cfg_valid = 1'b0, cfg_ready, cfg_en = 1'b0;
    logic [3:0] cfg_div = 4'h0, cfg_pllcfg = 4'h0;
    logic       pll_locked = 1'b0, pll_reset, cclk_en, busy, err_timeout, lock_lost;
    logic [3:0] cclk_div, cclk_pllcfg;

    eclock_ctrl #(.OFF_CYCLES(OFF), .PLLRST_CYCLES(PRST), .LOCK_TIMEOUT(LTO)) dut (
        .clk(clk), .nreset(nreset), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_en(cfg_en), .cfg_div(cfg_div), .cfg_pllcfg(cfg_pllcfg),
        .pll_locked(pll_locked), .pll_reset(pll_reset), .cclk_en(cclk_en),
        .cclk_div(cclk_div), .cclk_pllcfg(cclk_pllcfg), .busy(busy),
        .err_timeout(err_timeout), .lock_lost(lock_lost)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    // Expected outputs for one cycle: {ready, busy, en, div, pll, rst, err, lost}
    typedef struct {
        logic       ready, en, rst, err, lost;
        logic [3:0] div, pll;
    } exp_t;

    exp_t       sched[$];
    logic       st_en, st_err, st_lost;
    logic [3:0] st_div, st_pll;

    function automatic logic [13:0] obs();
        return {cfg_ready, busy, cclk_en, cclk_div, cclk_pllcfg, pll_reset, err_timeout, lock_lost};
    endfunction

    function automatic logic [13:0] pack_exp(input exp_t x);
        return {x.ready, ~x.ready, x.en, x.div, x.pll, x.rst, x.err, x.lost};
    endfunction

    function automatic exp_t steady();
        exp_t x;
        x.ready = 1'b1; x.en = st_en; x.rst = 1'b0; x.err = st_err;
        x.lost = st_lost; x.div = st_div; x.pll = st_pll;
        return x;
    endfunction

    task automatic push_n(input int n, input logic rst, input logic [3:0] div, input logic [3:0] pll);
        exp_t x;
        x.ready = 1'b0; x.en = 1'b0; x.rst = rst; x.err = 1'b0; x.lost = 1'b0;
        x.div = div; x.pll = pll;
        for (int i = 0; i < n; i++) sched.push_back(x);
    endtask

    // Accepted request -> per-cycle plan of phases (PLL locked assumed high).
    task automatic plan(input logic e, input logic [3:0] d, input logic [3:0] p);
        if ((p != st_pll) || st_err) begin
            push_n(PRST, 1'b1, st_div, p);
            push_n(1, 1'b0, st_div, p);
        end else if (st_en) begin
            push_n(OFF, 1'b0, st_div, st_pll);
        end
        push_n(1 + OFF, 1'b0, d, p);
        st_en = e && (d != DIV_OFF);
        st_div = d; st_pll = p; st_err = 1'b0; st_lost = 1'b0;
    endtask

    task automatic step(input logic v, input logic e, input logic [3:0] d, input logic [3:0] p,
                        input string name, output logic [13:0] seen);
        exp_t x;
        if (sched.size() != 0) x = sched.pop_front();
        else                   x = steady();
        seen = obs();
        check(name, 32'(seen), 32'(pack_exp(x)));
        cfg_valid = v; cfg_en = e; cfg_div = d; cfg_pllcfg = p;
        if (v && x.ready) plan(e, d, p);
        @(negedge clk);
    endtask

    task automatic settle(input string name);
        logic [13:0] seen;
        seen = '0;
        for (int k = 0; k < 200; k++) begin
            step(1'b0, 1'b0, 4'h0, 4'h0, name, seen);
            if (seen[13]) break;
        end
        check({name, "_done"}, 32'(seen[13]), 32'd1);
    endtask

    task automatic do_reset();
        int rst_hi, ready_at;
        cfg_valid = 1'b0; pll_locked = 1'b0; nreset = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_vals", 32'(obs()), 32'({1'b0, 1'b1, 1'b0, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0}));
        nreset = 1'b1;
        rst_hi = 0; ready_at = 0;
        for (int n = 1; n <= 200 && ready_at == 0; n++) begin
            @(negedge clk);
            if (pll_reset) rst_hi++;
            if (cfg_ready) ready_at = n;
            if (n == 20) pll_locked = 1'b1;
        end
        check("reset_pll_rst_len", 32'(rst_hi), 32'(PRST));
        check("reset_ready_cycle", 32'(ready_at), 32'(22 + OFF));
        check("reset_idle_outputs", 32'(obs()), 32'({1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0}));
        sched.delete();
        st_en = 1'b0; st_div = 4'h0; st_pll = 4'h0; st_err = 1'b0; st_lost = 1'b0;
    endtask

    typedef struct {
        logic       en;
        logic [3:0] div, pll;
        int         busy_len;
        logic       fen;
        logic [3:0] fdiv;
    } vec_t;

    vec_t tbl[9];

    initial begin
        logic [13:0] seen;
        int nb, rdy_cnt, rst_hi, err_at;
        logic [3:0] d, p;

        tbl[0] = '{1'b1, DIV_1,   4'd0, 1 + OFF,          1'b1, DIV_1};
        tbl[1] = '{1'b1, DIV_4,   4'd0, 1 + 2 * OFF,      1'b1, DIV_4};
        tbl[2] = '{1'b1, DIV_4,   4'd0, 1 + 2 * OFF,      1'b1, DIV_4};
        tbl[3] = '{1'b0, DIV_2,   4'd0, 1 + 2 * OFF,      1'b0, DIV_2};
        tbl[4] = '{1'b1, DIV_OFF, 4'd0, 1 + OFF,          1'b0, DIV_OFF};
        tbl[5] = '{1'b1, DIV_2,   4'd2, PRST + 2 + OFF,   1'b1, DIV_2};
        tbl[6] = '{1'b1, DIV_2,   4'd2, 1 + 2 * OFF,      1'b1, DIV_2};
        tbl[7] = '{1'b0, DIV_OFF, 4'd5, PRST + 2 + OFF,   1'b0, DIV_OFF};
        tbl[8] = '{1'b1, 4'h4,    4'd5, 1 + OFF,          1'b1, 4'h4};

        seen = '0;
        do_reset();

        for (int i = 0; i < 9; i++) begin
            step(1'b1, tbl[i].en, tbl[i].div, tbl[i].pll, "tbl_accept", seen);
            nb = 0;
            for (int k = 0; k < 200; k++) begin
                step(1'b0, 1'b0, 4'h0, 4'h0, "tbl_cycle", seen);
                if (seen[13]) break;
                nb++;
            end
            check("tbl_busy_len", 32'(nb), 32'(tbl[i].busy_len));
            check("tbl_final_en", 32'(seen[11]), 32'(tbl[i].fen));
            check("tbl_final_div", 32'(seen[10:7]), 32'(tbl[i].fdiv));
        end

        // Request held valid while busy: only ready cycles may capture it.
        step(1'b1, 1'b1, DIV_1, 4'd5, "hold_first", seen);
        rdy_cnt = 0;
        for (int k = 0; k < 40; k++) begin
            step(1'b1, 1'b1, DIV_2, 4'd5, "hold_cycle", seen);
            if (seen[13]) rdy_cnt++;
        end
        check("hold_ready_count", 32'(rdy_cnt), 32'd1);
        settle("hold_settle");
        check("hold_final_div", 32'(cclk_div), 32'(DIV_2));

        // Lock never arrives: PLL reset pulse, full timeout, ERROR.
        check("err_pre_ready", 32'(cfg_ready), 32'd1);
        pll_locked = 1'b0;
        cfg_valid = 1'b1; cfg_en = 1'b1; cfg_div = DIV_1; cfg_pllcfg = 4'd3;
        @(negedge clk);
        cfg_valid = 1'b0;
        rst_hi = 0; err_at = 0;
        for (int n = 1; n <= 1200 && err_at == 0; n++) begin
            if (n > 1) @(negedge clk);
            if (pll_reset) rst_hi++;
            if (err_timeout) err_at = n;
        end
        check("err_pll_rst_len", 32'(rst_hi), 32'(PRST));
        check("err_timeout_cycle", 32'(err_at), 32'(1 + PRST + LTO));
        check("err_state_outputs", 32'(obs()), 32'({1'b1, 1'b0, 1'b0, st_div, 4'd3, 1'b0, 1'b1, 1'b0}));
        st_en = 1'b0; st_pll = 4'd3; st_err = 1'b1; st_lost = 1'b0;
        pll_locked = 1'b1;
        step(1'b0, 1'b0, 4'h0, 4'h0, "err_sticky", seen);
        step(1'b1, 1'b1, DIV_2, 4'd3, "err_recover_accept", seen);
        step(1'b0, 1'b0, 4'h0, 4'h0, "err_cleared", seen);
        settle("err_recover_settle");
        check("err_recover_run", 32'(cclk_en), 32'd1);

`ifdef ECLOCK_CTRL_WATCHDOG_EN
        pll_locked = 1'b0;
        @(negedge clk);
        check("wd_first_low", 32'({cclk_en, lock_lost}), 32'b10);
        @(negedge clk);
        check("wd_trip", 32'({cclk_en, pll_reset, lock_lost}), 32'b011);
        pll_locked = 1'b1;
        nb = 0;
        for (int k = 0; k < 200 && !cfg_ready; k++) begin
            @(negedge clk);
            nb++;
        end
        check("wd_relock_cycles", 32'(nb), 32'(PRST + 1 + OFF));
        check("wd_back_in_run", 32'(obs()), 32'({1'b1, 1'b0, 1'b1, st_div, st_pll, 1'b0, 1'b0, 1'b1}));
        st_lost = 1'b1;
`else
        pll_locked = 1'b0;
        for (int k = 0; k < 4; k++) step(1'b0, 1'b0, 4'h0, 4'h0, "nowd_run_kept", seen);
        pll_locked = 1'b1;
`endif
        step(1'b1, 1'b0, DIV_OFF, 4'd3, "lost_clear_accept", seen);
        settle("lost_clear_settle");
        check("lost_cleared", 32'(lock_lost), 32'd0);

        // Randomized request stream against the phase-plan model.
        for (int k = 0; k < 400; k++) begin
            case ($urandom_range(0, 4))
                0:       d = DIV_OFF;
                1:       d = DIV_1;
                2:       d = DIV_2;
                3:       d = DIV_4;
                default: d = 4'($urandom_range(0, 15));
            endcase
            p = 4'($urandom_range(0, 2));
            step($urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)), d, p, "rand_cycle", seen);
        end
        settle("rand_settle");

        // Reset in the middle of a sequence discards the pending request.
        step(1'b1, 1'b1, DIV_1, 4'd6, "midrst_accept", seen);
        repeat (5) step(1'b0, 1'b0, 4'h0, 4'h0, "midrst_cycle", seen);
        do_reset();
        step(1'b0, 1'b0, 4'h0, 4'h0, "midrst_after", seen);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
